exp_taylor_arbiter: RTL and testbench
=====================================

EXP_TAYLOR_ARBITER -- requirements
Module: exp_taylor_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter FRACWIDTH, default 12, giving the operand and result fraction width.
REQ-003 The block SHALL have parameter TIMEOUT, default 32, giving the maximum number of WAIT cycles before an error response.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NREQ  per-requester request pending.
REQ-008 req_data  in  NREQ*FRACWIDTH  per-requester operand x; slice i is bits [i*FRACWIDTH +: FRACWIDTH].
REQ-009 req_ready  out  NREQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 cfg_terms  in  4  cycles from launch to early-read request; 0 means never early-read.
REQ-011 eu_iData  out  FRACWIDTH  operand to the exp unit.
REQ-012 eu_iDataValid  out  1  exp unit start strobe.
REQ-013 eu_oDataRead  out  1  exp unit early-terminate strobe.
REQ-014 eu_oData  in  FRACWIDTH  exp unit result.
REQ-015 eu_oDataValid  in  1  exp unit result valid.
REQ-016 rsp_valid  out  1  response available.
REQ-017 rsp_ready  in  1  consumer accepts the response.
REQ-018 rsp_id  out  3  index of the requester the response belongs to.
REQ-019 rsp_data  out  FRACWIDTH  captured result.
REQ-020 rsp_err  out  1  response is a timeout error.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, RUN, WAIT and RESP.
REQ-023 In IDLE with any req_valid high, the block SHALL grant the first requester with valid high, searching round-robin upward from pointer rr_ptr and wrapping at NREQ-1.
REQ-024 On a grant, req_ready[g], eu_iDataValid and eu_iData=req_data[g] SHALL all be driven combinationally in the same cycle; g, data and cfg_terms are latched and the FSM moves to RUN with term_cnt=1.
REQ-025 req_ready SHALL be all-zero outside an IDLE grant cycle, and eu_iDataValid SHALL be high only in a grant cycle.
REQ-026 In RUN, term_cnt SHALL increment every cycle.
REQ-027 In RUN, when the latched cfg_terms is nonzero and term_cnt equals it, eu_oDataRead SHALL pulse for exactly one cycle and the FSM moves to WAIT.
REQ-028 In RUN, when eu_oDataValid rises before the early-read, the result SHALL be captured and the FSM moves directly to RESP with no oDataRead pulse.
REQ-029 When the latched cfg_terms is 0, RUN SHALL end only on eu_oDataValid or on timeout.
REQ-030 In WAIT, eu_oDataValid SHALL capture eu_oData into rsp_data, set rsp_err=0 and move the FSM to RESP.
REQ-031 A wait counter SHALL count RUN plus WAIT cycles; when it reaches TIMEOUT without eu_oDataValid, the block SHALL set rsp_data=0 and rsp_err=1 and move to RESP.
REQ-032 In RESP, rsp_valid SHALL be high and rsp_id, rsp_data and rsp_err SHALL be held stable until rsp_ready.
REQ-033 On rsp_valid and rsp_ready, the block SHALL set rr_ptr=(g+1) mod NREQ and return to IDLE; a new grant can occur no earlier than the next cycle.
REQ-034 Any eu_oDataValid in IDLE or RESP SHALL be ignored (stale result).
REQ-035 A req_valid drop by a non-granted requester SHALL have no effect; requests are not queued internally.
REQ-036 A latched request SHALL be served to completion regardless of later req_valid or cfg_terms changes.

Reset
REQ-037 While rst is high at a clock edge, the block SHALL set the state to IDLE, rr_ptr=0, term_cnt=0, wait counter=0, rsp_data=0, rsp_id=0 and rsp_err=0.
REQ-038 The outputs req_ready, eu_iDataValid, eu_oDataRead, rsp_valid and busy SHALL be 0 during and after reset until the next grant.
REQ-039 A reset mid-operation (RUN, WAIT or RESP) SHALL abandon the operation with no response.
REQ-040 eu_iData SHALL be 0 when not granting.

Verification
REQ-041 Single requester, req_valid=0001, data=0x400, cfg_terms=5: launch in cycle 0, oDataRead in cycle 5 only; the model returns 0x520 the following cycle, giving rsp_id=0, rsp_data=0x520, rsp_err=0.
REQ-042 All four requesters valid continuously with rsp_ready=1: the grant order is 0,1,2,3,0, with exactly one eu_iDataValid per response.
REQ-043 cfg_terms=0 with the model asserting valid 9 cycles after launch: no oDataRead pulse, and the response arrives with the correct data.
REQ-044 The model never asserts valid with TIMEOUT=32: rsp_err=1 and rsp_data=0 in cycle 33 after launch, and rr_ptr advances.
REQ-045 rsp_ready held low for 10 cycles: the response stays stable, there are no new grants, and a stale eu_oDataValid during RESP is ignored.
REQ-046 rst asserted in WAIT: the next cycle is IDLE with all outputs 0, and a subsequent request to requester 2 is granted normally.

Source files
------------

// File: rtl/exp_taylor_arbiter_if.sv
// rtl/exp_taylor_arbiter_if.sv - request, exp-unit and response signal bundle for exp_taylor_arbiter
interface exp_taylor_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int FRACWIDTH = 12
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*FRACWIDTH-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic [3:0]                cfg_terms;
  logic [FRACWIDTH-1:0]      eu_iData;
  logic                      eu_iDataValid;
  logic                      eu_oDataRead;
  logic [FRACWIDTH-1:0]      eu_oData;
  logic                      eu_oDataValid;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [2:0]                rsp_id;
  logic [FRACWIDTH-1:0]      rsp_data;
  logic                      rsp_err;
  logic                      busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, cfg_terms, eu_oData, eu_oDataValid, rsp_ready,
    output req_ready, eu_iData, eu_iDataValid, eu_oDataRead,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  // Requesters, exp unit and response consumer side
  modport master (
    output req_valid, req_data, cfg_terms, eu_oData, eu_oDataValid, rsp_ready,
    input  req_ready, eu_iData, eu_iDataValid, eu_oDataRead,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/exp_taylor_arbiter.sv
// rtl/exp_taylor_arbiter.sv - round-robin arbiter sharing one Taylor-series exp unit among NREQ requesters
module exp_taylor_arbiter #(
  parameter int NREQ      = 4,
  parameter int FRACWIDTH = 12,
  parameter int TIMEOUT   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  exp_taylor_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int             WCW      = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(TIMEOUT - 1);
  localparam logic [2:0]     LAST_IDX = 3'(NREQ - 1);

  logic [1:0]           r_state;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_gnt;
  logic [3:0]           r_cfg_terms;
  logic [3:0]           r_term_cnt;
  logic [WCW-1:0]       r_wait_cnt;
  logic [FRACWIDTH-1:0] r_rsp_data;
  logic                 r_rsp_err;

  logic [7:0]           w_valid_ext;
  logic                 w_found;
  logic [2:0]           w_gnt_idx;
  logic [3:0]           w_sum;
  logic [FRACWIDTH-1:0] w_gnt_data;
  logic                 w_grant;
  logic                 w_timeout;
  logic                 w_early;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping at NREQ-1
  always_comb begin
    w_valid_ext = 8'(bus.req_valid);
    w_found     = 1'b0;
    w_gnt_idx   = r_rr_ptr;
    w_sum       = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(NREQ)) begin
        w_sum = w_sum - 4'(NREQ);
      end
      if (!w_found && w_valid_ext[w_sum[2:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[2:0];
      end
    end
  end

  // Operand of the winning requester
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == 3'(i)) begin
        w_gnt_data = bus.req_data[i*FRACWIDTH +: FRACWIDTH];
      end
    end
  end

  // Grant, timeout and early-read decisions; outputs are forced low while rst is high
  always_comb begin
    w_grant   = !rst && (r_state == S_IDLE) && w_found;
    w_timeout = ((r_state == S_RUN) || (r_state == S_WAIT)) && (r_wait_cnt == W_LAST);
    // A result arriving in the same cycle as the planned early read wins, and timeout beats the read
    w_early   = (r_state == S_RUN) && (r_cfg_terms != 4'd0) && (r_term_cnt == r_cfg_terms) &&
                !bus.eu_oDataValid && !w_timeout;
  end

  // Handshake and response outputs
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = w_grant && (w_gnt_idx == 3'(i));
    end
    bus.eu_iDataValid = w_grant;
    bus.eu_iData      = w_grant ? w_gnt_data : '0;
    bus.eu_oDataRead  = !rst && w_early;
    bus.rsp_valid     = !rst && (r_state == S_RESP);
    bus.busy          = !rst && (r_state != S_IDLE);
    bus.rsp_id        = r_gnt;
    bus.rsp_data      = r_rsp_data;
    bus.rsp_err       = r_rsp_err;
  end

  // FSM, latched request and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_cfg_terms <= '0;
      r_term_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt       <= w_gnt_idx;
            r_cfg_terms <= bus.cfg_terms;
            r_term_cnt  <= 4'd1;
            r_wait_cnt  <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN, S_WAIT: begin
          r_term_cnt <= r_term_cnt + 4'd1;
          r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (bus.eu_oDataValid) begin
            r_rsp_data <= bus.eu_oData;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else if (w_early) begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            r_rr_ptr <= (r_gnt == LAST_IDX) ? 3'd0 : r_gnt + 3'd1;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_taylor_arbiter.sv
// tb/tb_exp_taylor_arbiter.sv - self-checking bench for exp_taylor_arbiter
module tb_exp_taylor_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 12;
  localparam int TO   = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   model_rr;

  exp_taylor_arbiter_if #(.NREQ(NREQ), .FRACWIDTH(FW)) bus ();

  exp_taylor_arbiter #(.NREQ(NREQ), .FRACWIDTH(FW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] base;
    int          t;
    int          l;
    int          d;
    int          eg;
    int          erd;
    int          eresp;
    logic [11:0] edata;
    logic        eerr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  // Exp unit stand-in: x + x/4 + x/32 (0x400 -> 0x520)
  function automatic logic [11:0] f(input logic [11:0] x);
    return 12'(x + (x >> 2) + (x >> 5));
  endfunction

  function automatic logic [19:0] get_ctl();
    return {bus.req_ready, bus.eu_iDataValid, bus.eu_iData,
            bus.eu_oDataRead, bus.rsp_valid, bus.busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_data(input logic [11:0] base);
    for (int i = 0; i < NREQ; i++) bus.req_data[i*FW +: FW] = 12'(base + 12'(i));
  endtask

  // Reference arbitration: first requester with valid high, scanning upward from the pointer
  function automatic int model_grant(input logic [3:0] m);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (model_rr + k) % NREQ;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Reference timeline in cycles after launch: early-read cycle, first RESP cycle, response
  task automatic predict(input int t, input int l, input logic [11:0] x,
                         output int rd, output int rs, output logic [11:0] ed, output logic ee);
    int arrive;
    if (t != 0 && (l == 0 || t < l)) begin
      rd = t;
      arrive = t + 1;
    end else begin
      rd = 0;
      arrive = l;
    end
    if (arrive != 0 && arrive <= TO) begin
      rs = arrive + 1; ed = f(x); ee = 1'b0;
    end else begin
      rs = TO + 1; ed = 12'h000; ee = 1'b1;
    end
  endtask

  // One transaction from grant cycle through response acceptance
  task automatic run_txn(input logic [3:0] mask, input logic [11:0] base, input int t, input int l,
                         input int d, input int eg, input int erd, input int eresp,
                         input logic [11:0] edata, input logic eerr);
    logic [11:0] x_rx;
    logic        prev_rd;
    logic        done;
    logic        v;
    int          c;
    bus.req_valid     = mask;
    set_data(base);
    bus.cfg_terms     = 4'(t);
    bus.eu_oDataValid = 1'($urandom);
    bus.eu_oData      = 12'($urandom);
    bus.rsp_ready     = 1'($urandom);
    #1;
    chk("grant", 64'(get_ctl()), 64'({4'(1 << eg), 1'b1, 12'(base + 12'(eg)), 3'b000}));
    x_rx = bus.eu_iData;
    tick();
    prev_rd = 1'b0;
    done    = 1'b0;
    for (c = 1; c < eresp; c++) begin
      bus.req_valid     = 4'($urandom);
      bus.cfg_terms     = 4'($urandom);
      bus.rsp_ready     = 1'($urandom);
      v                 = !done && ((c == l) || prev_rd);
      bus.eu_oDataValid = v;
      bus.eu_oData      = v ? f(x_rx) : 12'($urandom);
      if (v) done = 1'b1;
      #1;
      chk("run", 64'(get_ctl()), 64'({4'b0, 1'b0, 12'h000, (c == erd), 1'b0, 1'b1}));
      prev_rd = bus.eu_oDataRead;
      tick();
    end
    for (int k = 0; k <= d; k++) begin
      bus.req_valid     = 4'($urandom);
      bus.cfg_terms     = 4'($urandom);
      bus.eu_oDataValid = (!done && c == l) || (k < d && 1'($urandom));
      bus.eu_oData      = 12'($urandom);
      bus.rsp_ready     = (k == d);
      #1;
      chk("resp_ctl", 64'(get_ctl()), 64'({4'b0, 1'b0, 12'h000, 3'b011}));
      chk("resp", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 64'({3'(eg), edata, eerr}));
      tick();
      c++;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; model_rr = 0;
    tbl[0]  = '{4'b1111, 12'h100, 0, 3,  0,  0, 0, 4,  12'h148, 1'b0};
    tbl[1]  = '{4'b1111, 12'h100, 0, 3,  0,  1, 0, 4,  12'h149, 1'b0};
    tbl[2]  = '{4'b1111, 12'h100, 0, 3,  0,  2, 0, 4,  12'h14A, 1'b0};
    tbl[3]  = '{4'b1111, 12'h100, 0, 3,  0,  3, 0, 4,  12'h14B, 1'b0};
    tbl[4]  = '{4'b1111, 12'h100, 0, 3,  0,  0, 0, 4,  12'h148, 1'b0};
    tbl[5]  = '{4'b0001, 12'h400, 5, 0,  0,  0, 5, 7,  12'h520, 1'b0};
    tbl[6]  = '{4'b0010, 12'h200, 0, 9,  0,  1, 0, 10, 12'h291, 1'b0};
    tbl[7]  = '{4'b0100, 12'h300, 0, 0,  0,  2, 0, 33, 12'h000, 1'b1};
    tbl[8]  = '{4'b1000, 12'h040, 3, 0,  10, 3, 3, 5,  12'h055, 1'b0};
    tbl[9]  = '{4'b0011, 12'h010, 4, 4,  0,  0, 0, 5,  12'h014, 1'b0};
    tbl[10] = '{4'b0001, 12'h400, 0, 32, 0,  0, 0, 33, 12'h520, 1'b0};
    tbl[11] = '{4'b0010, 12'h200, 0, 33, 0,  1, 0, 33, 12'h000, 1'b1};

    rst = 1'b1;
    bus.req_valid = 4'b1111; set_data(12'h000); bus.cfg_terms = 4'd0;
    bus.eu_oData = 12'h000; bus.eu_oDataValid = 1'b1; bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ctl", 64'(get_ctl()), 64'h0);
    chk("rst_rsp", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 64'h0);
    rst = 1'b0;
    bus.req_valid = 4'b0000; bus.eu_oDataValid = 1'b0;
    #1;
    chk("idle_ctl", 64'(get_ctl()), 64'h0);
    tick();

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].mask, tbl[i].base, tbl[i].t, tbl[i].l, tbl[i].d,
              tbl[i].eg, tbl[i].erd, tbl[i].eresp, tbl[i].edata, tbl[i].eerr);
    end

    // Reset while waiting for the early-read result
    bus.req_valid = 4'b0010; set_data(12'h700); bus.cfg_terms = 4'd2; bus.eu_oDataValid = 1'b0;
    #1;
    chk("mr_grant", 64'(get_ctl()), 64'({4'b0010, 1'b1, 12'h701, 3'b000}));
    tick();
    bus.cfg_terms = 4'd0;
    #1;
    chk("mr_run", 64'(get_ctl()), 64'({4'b0, 1'b0, 12'h000, 3'b001}));
    tick();
    #1;
    chk("mr_read", 64'(get_ctl()), 64'({4'b0, 1'b0, 12'h000, 3'b101}));
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rst", 64'(get_ctl()), 64'h0);
    tick();
    rst = 1'b0; bus.req_valid = 4'b0000;
    #1;
    chk("mr_idle", 64'(get_ctl()), 64'h0);
    chk("mr_rsp", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 64'h0);
    tick();
    run_txn(4'b0100, 12'h7F0, 0, 5, 0, 2, 0, 6, f(12'h7F2), 1'b0);
    model_rr = 3;

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  m;
      logic [11:0] b;
      logic [11:0] ed;
      logic        ee;
      int          t, l, d, g, rd, rs;
      m = 4'($urandom_range(1, 15));
      b = 12'($urandom);
      t = $urandom_range(0, 15);
      l = $urandom_range(0, 36);
      if (t != 0 && l == t) l++;
      d = $urandom_range(0, 3);
      g = model_grant(m);
      predict(t, l, 12'(b + 12'(g)), rd, rs, ed, ee);
      run_txn(m, b, t, l, d, g, rd, rs, ed, ee);
      model_rr = (g + 1) % NREQ;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
